arp_cache: RTL and testbench

IPv4-to-MAC address cache: the storage end of the ARP cache-write channel driven by `arp_tx`, plus an IP-to-MAC lookup port for the IP transmit path. It stores learned (IP, MAC) pairs and answers lookups with hit/miss. On a miss it raises an ARP query trigger toward `arp_tx`, then waits for that query's response or a timeout.

---
 rtl/arp_cache_pkg.sv | 24 ++
 rtl/arp_cache_match.sv | 36 +++
 rtl/arp_cache.sv | 173 +++++++++++++++++
 tb/tb_arp_cache.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_cache_pkg.sv
// arp_pkg: shared types and constants for the ARP cache slice.
//   OPCODE_QUERY / OPCODE_RESPONSE : ARP opcode values
//   ARP_LENGTH                     : ARP payload length in bytes
//   arp_entry_t                    : one cache slot {valid, ip, mac}
//   w_state_t / l_state_t          : write and lookup FSM states
package arp_pkg;
  localparam logic [15:0] OPCODE_QUERY    = 16'h0001;
  localparam logic [15:0] OPCODE_RESPONSE = 16'h0002;
  localparam int          ARP_LENGTH      = 28;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [47:0] mac;
  } arp_entry_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {L_IDLE, L_SEARCH, L_RESULT} l_state_t;

  // Unspecified and broadcast addresses never name a real host.
  function automatic logic ip_storable(input logic [31:0] ip);
    return (ip != 32'h0000_0000) && (ip != 32'hFFFF_FFFF);
  endfunction
endpackage

// File: rtl/arp_cache_match.sv
// arp_cache_match: combinational table scan.
//   ip       in  address to find
//   entries  in  whole cache table
//   hit      out valid entry with matching ip exists; hit_idx = its slot
//   free     out some slot is invalid; free_idx = lowest such slot
module arp_cache_match
  import arp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [31:0]            ip,
  input  arp_entry_t [DEPTH-1:0] entries,
  output logic                   hit,
  output logic [IDX_W-1:0]       hit_idx,
  output logic                   free,
  output logic [IDX_W-1:0]       free_idx
);
  // Scan high to low so the last assignment is the lowest index.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].ip == ip) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entries[i].valid) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/arp_cache.sv
// arp_cache: IPv4 -> MAC cache.
//   arp_write_* / arp_store_* / arp_b*  three-phase write channel from arp_tx
//   lookup_* / lookup_r*                 lookup request and registered result
//   trig_arp_*                           ARP query trigger raised on a miss
// Write and lookup FSMs run independently; the only shared state is the
// table, written solely in W_COMMIT and read by the search in L_SEARCH.
module arp_cache
  import arp_pkg::*;
#(
  parameter int          CACHE_DEPTH   = 8,
  parameter logic [23:0] QUERY_TIMEOUT = 24'd12_500_000
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic [31:0] arp_write_ip_in,
  input  logic        arp_write_valid_in,
  output logic        arp_write_ready_out,
  input  logic [47:0] arp_store_mac_in,
  input  logic        arp_store_valid_in,
  output logic        arp_store_ready_out,
  input  logic        arp_bvalid_in,
  output logic        arp_bready_out,
  input  logic [31:0] lookup_ip_in,
  input  logic        lookup_valid_in,
  output logic        lookup_ready_out,
  output logic [47:0] lookup_mac_out,
  output logic        lookup_hit_out,
  output logic        lookup_rvalid_out,
  input  logic        lookup_rready_in,
  output logic        trig_arp_qvalid_out,
  output logic [31:0] trig_arp_ip_out,
  input  logic        trig_arp_qready_in
);
  localparam int IDX_W = $clog2(CACHE_DEPTH);

  arp_entry_t [CACHE_DEPTH-1:0] cache_q;
  w_state_t                     w_state;
  l_state_t                     l_state;
  logic [31:0]                  w_ip_q;
  logic [47:0]                  w_mac_q;
  logic [31:0]                  l_ip_q;
  logic [IDX_W-1:0]             victim_q;
  logic [23:0]                  q_cnt;

  logic             c_hit, c_free, s_hit;
  logic [IDX_W-1:0] c_hit_idx, c_free_idx, s_hit_idx;
  logic             s_free_unused;
  logic [IDX_W-1:0] s_free_idx_unused;

  arp_cache_match #(.DEPTH(CACHE_DEPTH), .IDX_W(IDX_W)) u_commit_match (
    .ip(w_ip_q), .entries(cache_q),
    .hit(c_hit), .hit_idx(c_hit_idx), .free(c_free), .free_idx(c_free_idx)
  );

  arp_cache_match #(.DEPTH(CACHE_DEPTH), .IDX_W(IDX_W)) u_search_match (
    .ip(l_ip_q), .entries(cache_q),
    .hit(s_hit), .hit_idx(s_hit_idx), .free(s_free_unused), .free_idx(s_free_idx_unused)
  );

  // Slot choice: refresh existing entry, else first hole, else evict victim.
  logic [IDX_W-1:0] tgt_idx;
  logic             do_store, adv_victim;
  always_comb begin
    tgt_idx    = victim_q;
    do_store   = 1'b0;
    adv_victim = 1'b0;
    if (ip_storable(w_ip_q)) begin
      do_store = 1'b1;
      if (c_hit)       tgt_idx = c_hit_idx;
      else if (c_free) tgt_idx = c_free_idx;
      else             adv_victim = 1'b1;
    end
  end

  // Write FSM, table and victim pointer.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      w_state             <= W_IDLE;
      w_ip_q              <= '0;
      w_mac_q             <= '0;
      cache_q             <= '0;
      victim_q            <= '0;
      arp_write_ready_out <= 1'b0;
      arp_store_ready_out <= 1'b0;
      arp_bready_out      <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE:
          if (arp_write_valid_in && arp_write_ready_out) begin
            w_ip_q              <= arp_write_ip_in;
            arp_write_ready_out <= 1'b0;
            arp_store_ready_out <= 1'b1;
            w_state             <= W_DATA;
          end else begin
            arp_write_ready_out <= 1'b1;
          end
        W_DATA:
          if (arp_store_valid_in && arp_store_ready_out) begin
            w_mac_q             <= arp_store_mac_in;
            arp_store_ready_out <= 1'b0;
            w_state             <= W_COMMIT;
          end
        W_COMMIT: begin
          if (do_store) cache_q[tgt_idx] <= '{valid: 1'b1, ip: w_ip_q, mac: w_mac_q};
          if (adv_victim) victim_q <= victim_q + 1'b1;
          arp_bready_out <= 1'b1;
          w_state        <= W_RESP;
        end
        W_RESP:
          if (arp_bvalid_in && arp_bready_out) begin
            arp_bready_out      <= 1'b0;
            arp_write_ready_out <= 1'b1;
            w_state             <= W_IDLE;
          end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Lookup FSM and miss-query trigger.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      l_state             <= L_IDLE;
      l_ip_q              <= '0;
      lookup_ready_out    <= 1'b0;
      lookup_rvalid_out   <= 1'b0;
      lookup_hit_out      <= 1'b0;
      lookup_mac_out      <= '0;
      trig_arp_qvalid_out <= 1'b0;
      trig_arp_ip_out     <= '0;
      q_cnt               <= '0;
    end else begin
      case (l_state)
        L_IDLE:
          if (lookup_valid_in && lookup_ready_out) begin
            l_ip_q           <= lookup_ip_in;
            lookup_ready_out <= 1'b0;
            l_state          <= L_SEARCH;
          end else begin
            lookup_ready_out <= 1'b1;
          end
        L_SEARCH: begin
          lookup_hit_out    <= s_hit;
          lookup_mac_out    <= s_hit ? cache_q[s_hit_idx].mac : 48'h0;
          lookup_rvalid_out <= 1'b1;
          l_state           <= L_RESULT;
        end
        L_RESULT:
          if (lookup_rready_in) begin
            lookup_rvalid_out <= 1'b0;
            lookup_ready_out  <= 1'b1;
            l_state           <= L_IDLE;
          end
        default: l_state <= L_IDLE;
      endcase

      // One query in flight at most; a miss seen while one is pending
      // (including its final cycle) is dropped.
      if (trig_arp_qvalid_out) begin
        if (trig_arp_qready_in || q_cnt == QUERY_TIMEOUT - 24'd1) begin
          trig_arp_qvalid_out <= 1'b0;
          q_cnt               <= '0;
        end else begin
          q_cnt <= q_cnt + 24'd1;
        end
      end else if (l_state == L_SEARCH && !s_hit) begin
        trig_arp_qvalid_out <= 1'b1;
        trig_arp_ip_out     <= l_ip_q;
        q_cnt               <= '0;
      end
    end
  end
endmodule

// File: tb/tb_arp_cache.sv
// Scoreboard bench for arp_cache: stimulus pushes expected lookup results and
// expected query IPs; monitors pop and compare when the DUT presents them.
module tb_arp_cache;
  logic        logic_clk = 1'b0;
  logic        logic_rst_n;
  logic [31:0] arp_write_ip_in;
  logic        arp_write_valid_in;
  logic        arp_write_ready_out;
  logic [47:0] arp_store_mac_in;
  logic        arp_store_valid_in;
  logic        arp_store_ready_out;
  logic        arp_bvalid_in;
  logic        arp_bready_out;
  logic [31:0] lookup_ip_in;
  logic        lookup_valid_in;
  logic        lookup_ready_out;
  logic [47:0] lookup_mac_out;
  logic        lookup_hit_out;
  logic        lookup_rvalid_out;
  logic        lookup_rready_in;
  logic        trig_arp_qvalid_out;
  logic [31:0] trig_arp_ip_out;
  logic        trig_arp_qready_in;

  arp_cache #(.CACHE_DEPTH(8), .QUERY_TIMEOUT(24'd16)) dut (
    .logic_clk(logic_clk), .logic_rst_n(logic_rst_n),
    .arp_write_ip_in(arp_write_ip_in), .arp_write_valid_in(arp_write_valid_in),
    .arp_write_ready_out(arp_write_ready_out),
    .arp_store_mac_in(arp_store_mac_in), .arp_store_valid_in(arp_store_valid_in),
    .arp_store_ready_out(arp_store_ready_out),
    .arp_bvalid_in(arp_bvalid_in), .arp_bready_out(arp_bready_out),
    .lookup_ip_in(lookup_ip_in), .lookup_valid_in(lookup_valid_in),
    .lookup_ready_out(lookup_ready_out), .lookup_mac_out(lookup_mac_out),
    .lookup_hit_out(lookup_hit_out), .lookup_rvalid_out(lookup_rvalid_out),
    .lookup_rready_in(lookup_rready_in),
    .trig_arp_qvalid_out(trig_arp_qvalid_out), .trig_arp_ip_out(trig_arp_ip_out),
    .trig_arp_qready_in(trig_arp_qready_in)
  );

  always #5 logic_clk = ~logic_clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [48:0] lk_exp[$];   // {hit, mac}
  logic [31:0] q_exp[$];    // IP of each expected query rising edge
  logic q_prev = 1'b0;
  int   q_run = 0;
  int   q_len = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ipb(input int n);
    return 32'hC0A8_0000 | 32'(n);
  endfunction

  function automatic logic [47:0] mac_of(input int n);
    return 48'h0200_0000_0000 + 48'(n);
  endfunction

  // Lookup result monitor.
  always @(negedge logic_clk) begin
    if (logic_rst_n && lookup_rvalid_out && lookup_rready_in) begin
      if (lk_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL lk_unexpected: got result ip-less hit=%0d mac=%h, none expected",
                 lookup_hit_out, lookup_mac_out);
      end else begin
        logic [48:0] e;
        e = lk_exp.pop_front();
        chk("lk_hit", 64'(lookup_hit_out), 64'(e[48]));
        chk("lk_mac", 64'(lookup_mac_out), 64'(e[47:0]));
      end
    end
  end

  // Query monitor: checks IP on every rising edge and records pulse length.
  always @(negedge logic_clk) begin
    if (!logic_rst_n) begin
      q_prev = 1'b0;
      q_run  = 0;
    end else begin
      if (trig_arp_qvalid_out && !q_prev) begin
        if (q_exp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL q_unexpected: got query ip %h, none expected", trig_arp_ip_out);
        end else begin
          chk("q_ip", 64'(trig_arp_ip_out), 64'(q_exp.pop_front()));
        end
      end
      if (trig_arp_qvalid_out) q_run++;
      else if (q_prev) begin
        q_len = q_run;
        q_run = 0;
      end
      q_prev = trig_arp_qvalid_out;
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, 64'({arp_write_ready_out, arp_store_ready_out, arp_bready_out,
                            lookup_ready_out, lookup_rvalid_out, lookup_hit_out,
                            trig_arp_qvalid_out}), 64'd0);
    chk({tag, "_mac"}, 64'(lookup_mac_out), 64'd0);
    chk({tag, "_qip"}, 64'(trig_arp_ip_out), 64'd0);
  endtask

  task automatic wr_addr(input logic [31:0] ip);
    int n = 0;
    @(negedge logic_clk);
    arp_write_ip_in = ip; arp_write_valid_in = 1'b1;
    while (!arp_write_ready_out && n < 50) begin @(negedge logic_clk); n++; end
    if (n >= 50) chk("wr_addr_wait", 64'(arp_write_ready_out), 64'd1);
    @(posedge logic_clk); #1 arp_write_valid_in = 1'b0;
  endtask

  task automatic wr_data(input logic [47:0] mac);
    int n = 0;
    @(negedge logic_clk);
    arp_store_mac_in = mac; arp_store_valid_in = 1'b1;
    while (!arp_store_ready_out && n < 50) begin @(negedge logic_clk); n++; end
    if (n >= 50) chk("wr_data_wait", 64'(arp_store_ready_out), 64'd1);
    @(posedge logic_clk); #1 arp_store_valid_in = 1'b0;
  endtask

  // Called just after the store handshake edge (end of cycle s).
  task automatic wr_resp();
    @(negedge logic_clk); chk("bready_s1", 64'(arp_bready_out), 64'd0);
    @(negedge logic_clk); chk("bready_s2", 64'(arp_bready_out), 64'd1);
    arp_bvalid_in = 1'b1;
    @(posedge logic_clk); #1 arp_bvalid_in = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] ip, input logic [47:0] mac);
    wr_addr(ip);
    wr_data(mac);
    wr_resp();
  endtask

  task automatic do_lookup(input logic [31:0] ip, input logic hit, input logic [47:0] mac);
    int n = 0;
    lk_exp.push_back({hit, mac});
    @(negedge logic_clk);
    lookup_ip_in = ip; lookup_valid_in = 1'b1;
    while (!lookup_ready_out && n < 50) begin @(negedge logic_clk); n++; end
    if (n >= 50) chk("lk_req_wait", 64'(lookup_ready_out), 64'd1);
    @(posedge logic_clk); #1 lookup_valid_in = 1'b0;
    @(negedge logic_clk); chk("lk_lat_t1", 64'(lookup_rvalid_out), 64'd0);
    @(negedge logic_clk); chk("lk_lat_t2", 64'(lookup_rvalid_out), 64'd1);
  endtask

  task automatic answer_query();
    int n = 0;
    while (!trig_arp_qvalid_out && n < 50) begin @(negedge logic_clk); n++; end
    chk("q_wait", 64'(trig_arp_qvalid_out), 64'd1);
    trig_arp_qready_in = 1'b1;
    @(posedge logic_clk); #1 trig_arp_qready_in = 1'b0;
    @(negedge logic_clk); chk("q_drop", 64'(trig_arp_qvalid_out), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic_rst_n = 1'b0;
    arp_write_ip_in = '0; arp_write_valid_in = 1'b0;
    arp_store_mac_in = '0; arp_store_valid_in = 1'b0;
    arp_bvalid_in = 1'b0;
    lookup_ip_in = '0; lookup_valid_in = 1'b0; lookup_rready_in = 1'b1;
    trig_arp_qready_in = 1'b0;

    repeat (3) @(negedge logic_clk);
    check_reset_outs("rst");
    logic_rst_n = 1'b1;
    #1 chk("rdy_pre_edge", 64'({arp_write_ready_out, lookup_ready_out}), 64'd0);
    @(negedge logic_clk);
    chk("rdy_post_edge", 64'({arp_write_ready_out, lookup_ready_out}), 64'd3);

    // Basic write then hit.
    do_write(ipb(10), 48'h0011_2233_4455);
    do_lookup(ipb(10), 1'b1, 48'h0011_2233_4455);

    // Miss raises a query, answered by a qready pulse.
    q_exp.push_back(32'hC0A8_0063);
    do_lookup(ipb(99), 1'b0, 48'h0);
    chk("q_ip_held", 64'(trig_arp_ip_out), 64'hC0A8_0063);
    answer_query();

    // Reset in the middle of the data phase.
    wr_addr(ipb(20));
    @(negedge logic_clk);
    chk("st_rdy_pre_rst", 64'(arp_store_ready_out), 64'd1);
    logic_rst_n = 1'b0;
    #1 check_reset_outs("rst_mid");
    @(negedge logic_clk); logic_rst_n = 1'b1;
    @(negedge logic_clk);

    // Table was cleared: miss, query times out; second miss raises nothing.
    q_exp.push_back(ipb(10));
    do_lookup(ipb(10), 1'b0, 48'h0);
    do_lookup(ipb(77), 1'b0, 48'h0);
    n = 0;
    while (trig_arp_qvalid_out && n < 60) begin @(negedge logic_clk); n++; end
    chk("q_timeout_drop", 64'(trig_arp_qvalid_out), 64'd0);
    @(negedge logic_clk);
    chk("q_len", 64'(q_len), 64'd16);

    // Fill, then round-robin eviction.
    for (int i = 1; i <= 8; i++) do_write(ipb(i), mac_of(i));
    do_write(ipb(9), mac_of(9));
    q_exp.push_back(ipb(1));
    do_lookup(ipb(1), 1'b0, 48'h0);
    answer_query();
    do_lookup(ipb(9), 1'b1, mac_of(9));
    do_write(ipb(10), mac_of(10));
    q_exp.push_back(ipb(2));
    do_lookup(ipb(2), 1'b0, 48'h0);
    answer_query();
    do_lookup(ipb(10), 1'b1, mac_of(10));
    do_lookup(ipb(3), 1'b1, mac_of(3));

    // Rewrite .3 in place.
    do_write(ipb(3), 48'hDEAD_BEEF_0003);
    do_lookup(ipb(3), 1'b1, 48'hDEAD_BEEF_0003);

    // Lookup searching in the commit cycle of another .3 update sees old MAC.
    wr_addr(ipb(3));
    @(negedge logic_clk);
    chk("race_st_rdy", 64'(arp_store_ready_out), 64'd1);
    chk("race_lk_rdy", 64'(lookup_ready_out), 64'd1);
    arp_store_mac_in = 48'hCAFE_0000_0333; arp_store_valid_in = 1'b1;
    lookup_ip_in = ipb(3); lookup_valid_in = 1'b1;
    lk_exp.push_back({1'b1, 48'hDEAD_BEEF_0003});
    @(posedge logic_clk); #1 arp_store_valid_in = 1'b0; lookup_valid_in = 1'b0;
    wr_resp();
    do_lookup(ipb(3), 1'b1, 48'hCAFE_0000_0333);

    // Victim pointer still at slot 2 (holding .3), so .11 evicts .3, not .4.
    do_write(ipb(11), mac_of(11));
    do_lookup(ipb(4), 1'b1, mac_of(4));
    q_exp.push_back(ipb(3));
    do_lookup(ipb(3), 1'b0, 48'h0);
    answer_query();
    do_lookup(ipb(11), 1'b1, mac_of(11));

    // Unspecified and broadcast IPs are not stored and evict nothing.
    do_write(32'h0000_0000, 48'h0000_0000_00A1);
    do_write(32'hFFFF_FFFF, 48'h0000_0000_00A2);
    do_lookup(ipb(4), 1'b1, mac_of(4));
    do_lookup(ipb(5), 1'b1, mac_of(5));

    // Stray qready with nothing pending.
    @(negedge logic_clk); trig_arp_qready_in = 1'b1;
    @(posedge logic_clk); #1 trig_arp_qready_in = 1'b0;
    @(negedge logic_clk);
    chk("q_stray", 64'(trig_arp_qvalid_out), 64'd0);

    repeat (3) @(negedge logic_clk);
    chk("lk_exp_drained", 64'(lk_exp.size()), 64'd0);
    chk("q_exp_drained", 64'(q_exp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
